fc_layer: RTL
=============

Name: fc_layer

Overview:
- Fully-connected (dense) stage directly downstream of the conv/merge/maxpool-ReLU branch.
- Consumes the flattened pooled feature map from the branch's max-ReLU result M10K. Computes OUT_NUM fixed-point dot products against a weight M10K, then adds a per-neuron bias.
- Writes the OUT_NUM results into its own result M10K. Started by the branch's done pulse; emits fc_done when the last neuron has been written.

Parameters:
- DATA_WIDTH, 18: signed fixed-point word width for data, weights, bias and result.
- FRACTION_WIDTH, 10: fractional bits; 1.0 = 2^FRACTION_WIDTH.
- ADDR_WIDTH, 12: width of all memory addresses.
- IN_NUM, 169: number of input features per neuron (pooled map size).
- OUT_NUM, 10: number of output neurons.
- ACC_WIDTH, 2*DATA_WIDTH: signed accumulator width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  start pulse; sampled only in IDLE.
- data_in  in  DATA_WIDTH  feature word, valid 1 cycle after data_addr_out.
- weight_in  in  DATA_WIDTH  weight word, valid 1 cycle after weight_addr_out.
- bias_in  in  DATA_WIDTH  bias word, valid 1 cycle after bias_addr_out.
- data_addr_out  out  ADDR_WIDTH  feature read address.
- weight_addr_out  out  ADDR_WIDTH  weight read address, equal to o*IN_NUM + i.
- bias_addr_out  out  ADDR_WIDTH  bias read address, equal to o.
- result_out  out  DATA_WIDTH  saturated neuron result.
- write_address_out  out  ADDR_WIDTH  result write address, equal to o.
- we_out  out  1  result write enable, 1-cycle pulse per neuron.
- fc_done  out  1  1-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; i=0, o=0, acc=0; every output is 0, including the addresses, result_out, we_out and fc_done.
- Reset asserted mid-operation aborts immediately. No write or done pulse is produced. A fresh run is required afterwards.
- Memories have 1-cycle registered read latency.
- States: IDLE, ISSUE, DRAIN, BIAS, WRITE, DONE.
- IDLE: on run=1, go to ISSUE with i=0, o=0, acc=0. Otherwise remain in IDLE.
- ISSUE:
  - Drive data_addr_out=i, weight_addr_out=o*IN_NUM+i (held in a running counter, no multiplier); bias_addr_out=o throughout.
  - A registered valid flag marks that the previous cycle issued a read.
  - When valid is set: acc += (data_in*weight_in) >>> FRACTION_WIDTH. The product is full 2*DATA_WIDTH signed; the shift is arithmetic.
  - When i==IN_NUM-1, go to DRAIN; otherwise i++.
- DRAIN: accumulate the final product, then go to BIAS.
- BIAS:
  - Register result_out = sat(acc + sign-extended bias_in). Bias is in the same Q format, so there is no shift.
  - Register write_address_out=o and we_out=1. Go to WRITE.
- sat(): clamp to the range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- WRITE:
  - we_out is high for exactly this cycle; acc is cleared.
  - If o==OUT_NUM-1, go to DONE. Otherwise o++, i=0, go to ISSUE.
- DONE: fc_done=1 for one cycle, then return to IDLE. result_out keeps its last value.
- Outside WRITE, we_out=0. Outside DONE, fc_done=0.
- run asserted in any state other than IDLE is ignored, including during DONE.
- Latency: each neuron takes IN_NUM+3 cycles. With run sampled at edge 0, fc_done is high in cycle 1+OUT_NUM*(IN_NUM+3).
- Accumulator overflow is not checked. ACC_WIDTH must cover IN_NUM*(2^(DATA_WIDTH-1))^2 >> FRACTION_WIDTH. Parameters must keep OUT_NUM*IN_NUM < 2^ADDR_WIDTH.

Decomposition:
- Package fc_pkg holds:
  - the state enum fc_state_t (IDLE, ISSUE, DRAIN, BIAS, WRITE, DONE);
  - a saturation function sat_to_width;
  - Q-format helper constants (ONE = 1<<FRACTION_WIDTH).
- Sub-module fc_mac is natural. It performs the signed multiply, arithmetic shift, accumulate with clear/enable, and final bias add with saturation. The FSM and address counters stay in fc_layer.

Test Plan:
- Basic run (IN_NUM=4, OUT_NUM=2, FRACTION_WIDTH=10): data all 1024, weights all 512, bias 256 → two writes of 2304, to addresses 0 and 1. fc_done is high in cycle 15.
- Negative and mixed values: data {1024,-2048,512,0}, weights {1024,1024,-2048,3072}, bias -512 → result -2560, written once per neuron.
- Saturation: data and weights all 65536 (64.0), bias 0 → result 131071. Negating the weights gives -131072.
- Address sequencing: OUT_NUM=3 → weight_addr_out runs 0..11 contiguously; bias_addr_out and write_address_out step 0,1,2; data_addr_out wraps 0..3 for each neuron.
- run pulse mid-ISSUE and during DONE → ignored: no restart, and the write count stays at OUT_NUM.
- reset dropped low during the second neuron → all outputs 0 immediately, no further we_out or fc_done. A subsequent run completes a full, correct pass.

Source files
------------

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared state encoding, Q-format constants and saturation helper for the dense stage
package fc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    BIAS,
    WRITE,
    DONE
  } fc_state_t;

  localparam int FRACTION_BITS = 10;
  localparam int ONE           = 1 << FRACTION_BITS;

  // Clamp a wide signed value into the signed range of a width-bit word.
  function automatic logic signed [63:0] sat_to_width(
    input logic signed [63:0] value,
    input int                 width
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/fc_mac.sv
// rtl/fc_mac.sv - signed fixed-point multiply-accumulate with bias add and output saturation
module fc_mac
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH     = 18,
  parameter int FRACTION_WIDTH = 10,
  parameter int ACC_WIDTH      = 2 * DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] data,
  input  logic signed [DATA_WIDTH-1:0] weight,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic signed [DATA_WIDTH-1:0] sum_sat
);

  localparam int EXT = ACC_WIDTH - DATA_WIDTH;

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] data_ext;
  logic signed [ACC_WIDTH-1:0] weight_ext;
  logic signed [ACC_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0] term;
  logic signed [63:0]          acc_wide;
  logic signed [63:0]          bias_wide;
  logic signed [63:0]          sum_wide;

  // Full-precision product rescaled back to Q format, plus biased and clamped view of the running sum
  always_comb begin
    data_ext   = {{EXT{data[DATA_WIDTH-1]}}, data};
    weight_ext = {{EXT{weight[DATA_WIDTH-1]}}, weight};
    product    = data_ext * weight_ext;
    term       = product >>> FRACTION_WIDTH;
    acc_wide   = {{(64 - ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
    bias_wide  = {{(64 - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
    sum_wide   = acc_wide + bias_wide;
    sum_sat    = DATA_WIDTH'(sat_to_width(sum_wide, DATA_WIDTH));
  end

  // Accumulator: clear has priority so a new neuron never inherits the previous sum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + term;
    end
  end

endmodule

// File: rtl/fc_layer.sv
// rtl/fc_layer.sv - dense layer sequencer: streams features and weights through the MAC and writes one result per neuron
module fc_layer
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH     = 18,
  parameter int FRACTION_WIDTH = 10,
  parameter int ADDR_WIDTH     = 12,
  parameter int IN_NUM         = 169,
  parameter int OUT_NUM        = 10,
  parameter int ACC_WIDTH      = 2 * DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic signed [DATA_WIDTH-1:0] weight_in,
  input  logic signed [DATA_WIDTH-1:0] bias_in,
  output logic [ADDR_WIDTH-1:0]        data_addr_out,
  output logic [ADDR_WIDTH-1:0]        weight_addr_out,
  output logic [ADDR_WIDTH-1:0]        bias_addr_out,
  output logic signed [DATA_WIDTH-1:0] result_out,
  output logic [ADDR_WIDTH-1:0]        write_address_out,
  output logic                         we_out,
  output logic                         fc_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_I = ADDR_WIDTH'(IN_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_O = ADDR_WIDTH'(OUT_NUM - 1);

  fc_state_t                   state;
  logic [ADDR_WIDTH-1:0]       i;
  logic [ADDR_WIDTH-1:0]       o;
  logic                        valid;
  logic                        mac_clear;
  logic signed [DATA_WIDTH-1:0] mac_sum;

  // Accumulator is zeroed on a fresh start and after each neuron's write
  always_comb begin
    mac_clear = 1'b0;
    if ((state == IDLE && run) || state == WRITE) begin
      mac_clear = 1'b1;
    end
  end

  fc_mac #(
    .DATA_WIDTH    (DATA_WIDTH),
    .FRACTION_WIDTH(FRACTION_WIDTH),
    .ACC_WIDTH     (ACC_WIDTH)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (mac_clear),
    .enable (valid),
    .data   (data_in),
    .weight (weight_in),
    .bias   (bias_in),
    .sum_sat(mac_sum)
  );

  // Sequencer: address counters, read-valid tracking and registered result/write/done outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      i                 <= '0;
      o                 <= '0;
      valid             <= 1'b0;
      data_addr_out     <= '0;
      weight_addr_out   <= '0;
      bias_addr_out     <= '0;
      result_out        <= '0;
      write_address_out <= '0;
      we_out            <= 1'b0;
      fc_done           <= 1'b0;
    end else begin
      valid   <= (state == ISSUE);
      we_out  <= 1'b0;
      fc_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state           <= ISSUE;
            i               <= '0;
            o               <= '0;
            data_addr_out   <= '0;
            weight_addr_out <= '0;
            bias_addr_out   <= '0;
          end
        end
        ISSUE: begin
          if (i == LAST_I) begin
            state <= DRAIN;
          end else begin
            i               <= i + 1'b1;
            data_addr_out   <= i + 1'b1;
            weight_addr_out <= weight_addr_out + 1'b1;
          end
        end
        DRAIN: begin
          state <= BIAS;
        end
        BIAS: begin
          result_out        <= mac_sum;
          write_address_out <= o;
          we_out            <= 1'b1;
          state             <= WRITE;
        end
        WRITE: begin
          if (o == LAST_O) begin
            fc_done <= 1'b1;
            state   <= DONE;
          end else begin
            o               <= o + 1'b1;
            i               <= '0;
            data_addr_out   <= '0;
            weight_addr_out <= weight_addr_out + 1'b1;
            bias_addr_out   <= o + 1'b1;
            state           <= ISSUE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
